// File: rtl/mux_4_1_rr_arbiter.sv
// 4-requester round-robin arbiter driving a 4:1 mux into one registered valid/ready stage.
// Define MUX_ARB_BURST_EN to let a grantee keep the channel for up to BURST_LEN transfers.
module mux_4_1_rr_arbiter #(
  parameter int W         = 4,
  parameter int BURST_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_len
    $error("BURST_LEN must be 1..15");
  end

  logic [1:0]   last_grant;
  logic [1:0]   g_rr;
  logic [1:0]   gsel;
  logic [1:0]   idx;
  logic         found;
  logic         load_en;
  logic         take;
  logic [W-1:0] sel_data;

  assign load_en = !out_valid || out_ready;
  assign take    = load_en && (|in_valid);

  always_comb begin
    g_rr  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && in_valid[idx]) begin
        g_rr  = idx;
        found = 1'b1;
      end
    end
  end

`ifdef MUX_ARB_BURST_EN
  logic [3:0] cnt;
  logic       hold;

  // count==0 only after reset, so the first grant always goes through the scan
  assign hold = (cnt != 4'd0) && (cnt < 4'(BURST_LEN))
             && in_valid[last_grant];
  assign gsel = hold ? last_grant : g_rr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (take) begin
      if (hold)
        cnt <= cnt + 4'd1;
      else
        cnt <= 4'd1;
    end
  end
`else
  assign gsel = g_rr;
`endif

  assign in_ready = take ? (4'b0001 << gsel) : 4'b0000;

  always_comb begin
    sel_data = in_data0;
    unique case (gsel)
      2'd0: sel_data = in_data0;
      2'd1: sel_data = in_data1;
      2'd2: sel_data = in_data2;
      2'd3: sel_data = in_data3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 2'd0;
      last_grant <= 2'd3;
    end else if (load_en) begin
      if (|in_valid) begin
        out_valid  <= 1'b1;
        out_data   <= sel_data;
        out_sel    <= gsel;
        last_grant <= gsel;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
